// File: rtl/adder_arb_if.sv
// rtl/adder_arb_if.sv - requester, response and shared-adder signals for adder_arb
interface adder_arb_if #(
  parameter int DATAWIDTH = 32
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic [DATAWIDTH-1:0] req0_a;
  logic [DATAWIDTH-1:0] req0_b;
  logic                 req0_sub;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [DATAWIDTH-1:0] req1_a;
  logic [DATAWIDTH-1:0] req1_b;
  logic                 req1_sub;

  logic                 rsp0_valid;
  logic                 rsp0_ready;
  logic [DATAWIDTH-1:0] rsp0_data;
  logic                 rsp1_valid;
  logic                 rsp1_ready;
  logic [DATAWIDTH-1:0] rsp1_data;

  logic [DATAWIDTH-1:0] add_a;
  logic [DATAWIDTH-1:0] add_b;
  logic                 add_sub;
  logic [DATAWIDTH-1:0] add_out;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sub,
    output req1_ready,
    output rsp0_valid, rsp0_data,
    input  rsp0_ready,
    output rsp1_valid, rsp1_data,
    input  rsp1_ready,
    output add_a, add_b, add_sub,
    input  add_out
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sub,
    input  req1_ready,
    input  rsp0_valid, rsp0_data,
    output rsp0_ready,
    input  rsp1_valid, rsp1_data,
    output rsp1_ready,
    input  add_a, add_b, add_sub,
    output add_out
  );
endinterface

// File: rtl/adder_arb.sv
// rtl/adder_arb.sv - two-requester arbiter sharing one external add/sub unit
// Define ADDER_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module adder_arb #(
  parameter int DATAWIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  adder_arb_if.slave  bus
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_owner, w_owner_nxt;
  logic [DATAWIDTH-1:0] r_result, w_result_nxt;

  logic w_rsp_done;
  logic w_can_accept;
  logic w_grant_any;
  logic w_grant_sel;

`ifndef ADDER_ARB_FIXED_PRIO_EN
  logic r_last, w_last_nxt;
`endif

  always_comb begin
    w_grant_sel = 1'b0;
`ifdef ADDER_ARB_FIXED_PRIO_EN
    w_grant_sel = ~bus.req0_valid;
`else
    if (bus.req0_valid && bus.req1_valid) w_grant_sel = ~r_last;
    else                                  w_grant_sel = ~bus.req0_valid;
`endif
  end

  // A completing response frees the result register for a same-cycle grant.
  assign w_rsp_done   = (r_state == RESP) && (r_owner ? bus.rsp1_ready : bus.rsp0_ready);
  assign w_can_accept = rst_n && ((r_state == IDLE) || w_rsp_done);
  assign w_grant_any  = w_can_accept && (bus.req0_valid || bus.req1_valid);

  always_comb begin
    bus.add_a      = '0;
    bus.add_b      = '0;
    bus.add_sub    = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    if (w_grant_any) begin
      bus.add_a      = w_grant_sel ? bus.req1_a   : bus.req0_a;
      bus.add_b      = w_grant_sel ? bus.req1_b   : bus.req0_b;
      bus.add_sub    = w_grant_sel ? bus.req1_sub : bus.req0_sub;
      bus.req0_ready = ~w_grant_sel;
      bus.req1_ready = w_grant_sel;
    end
    bus.rsp0_valid = (r_state == RESP) && !r_owner;
    bus.rsp1_valid = (r_state == RESP) &&  r_owner;
    bus.rsp0_data  = r_result;
    bus.rsp1_data  = r_result;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_result_nxt = r_result;
`ifndef ADDER_ARB_FIXED_PRIO_EN
    w_last_nxt   = r_last;
`endif
    if (w_grant_any) begin
      w_state_nxt  = RESP;
      w_owner_nxt  = w_grant_sel;
      w_result_nxt = bus.add_out;
`ifndef ADDER_ARB_FIXED_PRIO_EN
      w_last_nxt   = w_grant_sel;
`endif
    end else if (w_rsp_done) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_result <= '0;
`ifndef ADDER_ARB_FIXED_PRIO_EN
      r_last   <= 1'b1;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_result <= w_result_nxt;
`ifndef ADDER_ARB_FIXED_PRIO_EN
      r_last   <= w_last_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_adder_arb.sv
// tb/tb_adder_arb.sv - directed self-checking bench for adder_arb
module tb_adder_arb;
  localparam int DW = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  adder_arb_if #(.DATAWIDTH(DW)) bus ();

  adder_arb #(.DATAWIDTH(DW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External shared adder: modulo-2^DW add/subtract.
  assign bus.add_out = bus.add_sub ? (bus.add_a - bus.add_b) : (bus.add_a + bus.add_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = s;
  endtask

  task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = s;
  endtask

  initial begin
    logic g;
    logic [31:0] exp_data;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    set_req0(1'b1, 32'd5, 32'd7, 1'b0);
    set_req1(1'b1, 32'd1, 32'd1, 1'b0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;

    // Reset: requests present but nothing may be granted or driven.
    @(negedge clk);
    check("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
    check("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    check("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    check("rst_add_a",      bus.add_a,           32'd0);
    check("rst_rsp_data",   bus.rsp0_data,       32'd0);
    next_cycle();
    rst_n = 1'b1;
    set_req1(1'b0, 32'd0, 32'd0, 1'b0);

    // Single add 5+7.
    @(negedge clk);
    check("add_req0_ready", 32'(bus.req0_ready), 32'd1);
    check("add_add_a",      bus.add_a,           32'd5);
    next_cycle();
    set_req0(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("add_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    check("add_rsp0_data",  bus.rsp0_data,       32'd12);
    check("add_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    next_cycle();
    @(negedge clk);
    check("idle_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("idle_add_b",      bus.add_b,           32'd0);
    check("idle_add_sub",    32'(bus.add_sub),    32'd0);

    // Subtract wrap 0-1.
    next_cycle();
    set_req1(1'b1, 32'd0, 32'd1, 1'b1);
    @(negedge clk);
    check("sub_req1_ready", 32'(bus.req1_ready), 32'd1);
    check("sub_add_sub",    32'(bus.add_sub),    32'd1);
    next_cycle();
    set_req1(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("sub_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
    check("sub_rsp1_data",  bus.rsp1_data,       32'hFFFF_FFFF);
    next_cycle();

    // Contention: 10+1=11 on req0, 20-3=17 on req1, one result per cycle.
    set_req0(1'b1, 32'd10, 32'd1, 1'b0);
    set_req1(1'b1, 32'd20, 32'd3, 1'b1);
    g = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
      g = 1'b0;
`else
      g = k[0];
`endif
      @(negedge clk);
      check($sformatf("cont%0d_req0_ready", k), 32'(bus.req0_ready), 32'(!g));
      check($sformatf("cont%0d_req1_ready", k), 32'(bus.req1_ready), 32'(g));
      if (k > 0) begin
`ifdef ADDER_ARB_FIXED_PRIO_EN
        check($sformatf("cont%0d_rsp0_data", k), bus.rsp0_data, 32'd11);
        check($sformatf("cont%0d_rsp0_valid", k), 32'(bus.rsp0_valid), 32'd1);
`else
        exp_data = k[0] ? 32'd11 : 32'd17;
        check($sformatf("cont%0d_rsp_data", k), bus.rsp0_data, exp_data);
        check($sformatf("cont%0d_rsp1_valid", k), 32'(bus.rsp1_valid), 32'(!k[0]));
`endif
      end
      next_cycle();
    end
    set_req0(1'b0, 32'd0, 32'd0, 1'b0);
    set_req1(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    exp_data = g ? 32'd17 : 32'd11;
    check("cont_last_data",       bus.rsp0_data,       exp_data);
    check("cont_last_rsp1_valid", 32'(bus.rsp1_valid), 32'(g));
    next_cycle();

    // Backpressure: hold 100-50 while req1 (3+4) waits.
    bus.rsp0_ready = 1'b0;
    set_req0(1'b1, 32'd100, 32'd50, 1'b1);
    @(negedge clk);
    check("bp_req0_ready", 32'(bus.req0_ready), 32'd1);
    next_cycle();
    set_req0(1'b0, 32'd0, 32'd0, 1'b0);
    set_req1(1'b1, 32'd3, 32'd4, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_rsp0_valid", k), 32'(bus.rsp0_valid), 32'd1);
      check($sformatf("bp%0d_rsp0_data", k),  bus.rsp0_data,       32'd50);
      check($sformatf("bp%0d_req1_ready", k), 32'(bus.req1_ready), 32'd0);
      next_cycle();
    end
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    check("bp_rel_req1_ready", 32'(bus.req1_ready), 32'd1);
    check("bp_rel_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    next_cycle();
    set_req1(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("bp_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
    check("bp_rsp1_data",  bus.rsp1_data,       32'd7);
    check("bp_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    next_cycle();

    // Reset mid-RESP after a req0 grant; pointer must return to favour req0.
    bus.rsp0_ready = 1'b0;
    set_req0(1'b1, 32'd1, 32'd1, 1'b0);
    next_cycle();
    set_req0(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("mid_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("mid_rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    check("mid_rst_data",       bus.rsp0_data,       32'd0);
    next_cycle();
    rst_n = 1'b1;
    bus.rsp0_ready = 1'b1;
    set_req0(1'b1, 32'd2, 32'd2, 1'b0);
    set_req1(1'b1, 32'd9, 32'd9, 1'b0);
    @(negedge clk);
    check("post_rst_req0_ready", 32'(bus.req0_ready), 32'd1);
    check("post_rst_req1_ready", 32'(bus.req1_ready), 32'd0);
    next_cycle();
    set_req0(1'b0, 32'd0, 32'd0, 1'b0);
    set_req1(1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("post_rst_rsp0_data", bus.rsp0_data, 32'd4);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/adder_arb.md
ADDER_ARB -- requirements
Module: adder_arb

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 32, giving the operand and result width.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-004 For each requester i in {0,1}, the block SHALL have: req<i>_valid in 1, req<i>_ready out 1, req<i>_a in DATAWIDTH, req<i>_b in DATAWIDTH, req<i>_sub in 1 (0 add, 1 sub).
REQ-005 For each requester i, the block SHALL have: rsp<i>_valid out 1, rsp<i>_ready in 1, rsp<i>_data out DATAWIDTH.
REQ-006 The block SHALL have the shared-adder ports add_a out DATAWIDTH, add_b out DATAWIDTH, add_sub out 1, and add_out in DATAWIDTH; add_out is a purely combinational function of the three outputs.

Function
REQ-007 The state machine SHALL have two states: IDLE (no result held) and RESP (one result held for owner o).
REQ-008 In IDLE, if any reqX_valid is high, the block SHALL grant exactly one requester g in the same cycle.
REQ-009 In IDLE, the grant SHALL drive add_a/add_b/add_sub from g's operands and assert reqg_ready.
REQ-010 On the rising edge after a grant, the block SHALL latch add_out into the result register, set o=g, and move to RESP.
REQ-011 The result is therefore SHALL be visible with one-cycle latency from the accepting edge.
REQ-012 With no grant, add_a, add_b and add_sub SHALL be driven to zero.
REQ-013 The non-granted requester's ready SHALL be low.
REQ-014 In RESP, rspo_valid SHALL be high and rspo_data SHALL equal the result register.
REQ-015 In RESP, the other requester's rsp_valid SHALL be low.
REQ-016 Each rsp_data SHALL hold the result register value at all times; it is meaningful only while its rsp_valid is high.
REQ-017 In RESP with rspo_ready low, the result register, the owner o and rspo_valid SHALL be held stable, and no request SHALL be accepted.
REQ-018 In RESP with rspo_ready high, the response SHALL complete that cycle.
REQ-019 If a request is pending in the same cycle the response completes, a new grant SHALL be made that same cycle per REQ-008/009/010, and the block SHALL stay in RESP.
REQ-020 If no request is pending when the response completes, the block SHALL return to IDLE.
REQ-021 Arbitration SHALL be round-robin: with both requesters valid, the requester not granted last wins.
REQ-022 The last-grant pointer SHALL update only on an actual grant.
REQ-023 A request, once valid, SHALL stay asserted with stable operands until its ready is seen; behaviour on violation is undefined.
REQ-024 Add/sub arithmetic SHALL be modulo 2^DATAWIDTH; carry and overflow are discarded inside the adder.

Reset
REQ-025 While rst_n is low, the block SHALL be in IDLE.
REQ-026 While rst_n is low, the last-grant pointer SHALL be 1, so requester 0 has first priority.
REQ-027 While rst_n is low, the result register SHALL be 0.
REQ-028 While rst_n is low, all ready and rsp_valid outputs SHALL be 0 and all add_* outputs SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL discard any held result without a response.

Configuration
REQ-030 When macro ADDER_ARB_FIXED_PRIO_EN is defined, arbitration SHALL be fixed priority with requester 0 always winning, and the last-grant pointer SHALL be removed.
REQ-031 When ADDER_ARB_FIXED_PRIO_EN is undefined, arbitration SHALL be round-robin per REQ-021.

Verification
REQ-032 Reset scenario: assert rst_n=0 mid-RESP -> rsp0_valid=rsp1_valid=0 immediately; after release the block is in IDLE and the first grant with both valid goes to requester 0.
REQ-033 Single-add scenario: req0 a=5, b=7, sub=0, rsp0_ready=1 -> req0_ready=1 in cycle 0, rsp0_valid=1 with rsp0_data=12 in cycle 1.
REQ-034 Subtract-wrap scenario: req1 a=0, b=1, sub=1 -> rsp1_data=0xFFFFFFFF.
REQ-035 Contention scenario: both requesters valid continuously with rsp ready=1 -> grants alternate 0,1,0,1 at one result per cycle; with ADDER_ARB_FIXED_PRIO_EN defined -> grants are always 0.
REQ-036 Backpressure scenario: rsp0_ready=0 for 3 cycles while req1 is valid -> rsp0_data held stable, req1_ready=0; when rsp0_ready=1 -> req1 granted in that same cycle and rsp1_valid=1 in the next cycle.
